// File: rtl/approx_rca_pipe.sv
// approx_rca_pipe: pipelined ripple-carry adder with a runtime-selectable
// approximate LSB segment. Approximate cells take S = Y, Cout = X and ignore
// their carry-in. An exact carry chain runs in parallel with the datapath so
// every result carries a flag saying whether it equals the true sum. A
// saturating counter tallies delivered results that were not exact.
//
// Pipeline layout: an index p in 0..STAGES labels the boundary in front of
// stage p. Boundary 0 is the input port. Boundary p+1 is the register of
// stage p. Boundary STAGES is therefore the output register, and every
// stage reads boundary p and writes boundary p+1.
module approx_rca_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8,
    parameter int STAGES      = 2,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_exact,
    output logic [ERR_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam int SEG = WIDTH / STAGES;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // The carry chain can only be cut evenly.
    if (WIDTH % STAGES != 0) begin : g_bad_stages
        $error("approx_rca_pipe: WIDTH must be a multiple of STAGES");
    end
    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
        $error("approx_rca_pipe: APPROX_BITS must lie in 0..WIDTH");
    end

    // Boundary signals. Index 0 is the input port, index STAGES is the output.
    logic [STAGES:0] pv;                // valid
    logic [STAGES:0] rdy;               // stage p may load this cycle
    logic [STAGES:0] pcarry;            // datapath carry out of the bits done so far
    logic [WIDTH-1:0] pa     [STAGES+1];
    logic [WIDTH-1:0] pb     [STAGES+1];
    logic [WIDTH-1:0] psum   [STAGES+1];
    logic [WIDTH-1:0] pesum  [STAGES+1];
    logic             pax    [STAGES+1];
    logic             pecarry[STAGES+1];
    logic             pexact [STAGES+1];

    assign pv[0]      = in_valid;
    assign pa[0]      = in_a;
    assign pb[0]      = in_b;
    assign pax[0]     = approx_en;
    assign psum[0]    = '0;
    assign pesum[0]   = '0;
    assign pcarry[0]  = 1'b0;
    assign pecarry[0] = 1'b0;
    assign pexact[0]  = 1'b1;

    // Backpressure: a stage can load when it is empty or its content moves on.
    always_comb begin
        rdy = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~pv[k+1] | rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic             valid_q,  valid_d;
        logic [WIDTH-1:0] a_q,      a_d;
        logic [WIDTH-1:0] b_q,      b_d;
        logic             ax_q,     ax_d;
        logic [WIDTH-1:0] sum_q,    sum_d;
        logic             carry_q,  carry_d;
        logic [WIDTH-1:0] esum_q,   esum_d;
        logic             ecarry_q, ecarry_d;
        logic             exact_q,  exact_d;
        logic             take;
        logic             c_apx;
        logic             c_ext;
        logic             x_bit;
        logic             y_bit;

        assign take = rdy[gi] & pv[gi];

        // Ripple segment gi through both chains; everything else is forwarded.
        always_comb begin
            valid_d  = rdy[gi] ? pv[gi] : valid_q;
            a_d      = a_q;
            b_d      = b_q;
            ax_d     = ax_q;
            sum_d    = sum_q;
            carry_d  = carry_q;
            esum_d   = esum_q;
            ecarry_d = ecarry_q;
            exact_d  = exact_q;
            c_apx    = pcarry[gi];
            c_ext    = pecarry[gi];
            x_bit    = 1'b0;
            y_bit    = 1'b0;
            if (take) begin
                a_d    = pa[gi];
                b_d    = pb[gi];
                ax_d   = pax[gi];
                sum_d  = psum[gi];
                esum_d = pesum[gi];
                for (int j = 0; j < SEG; j++) begin
                    x_bit = pa[gi][gi*SEG + j];
                    y_bit = pb[gi][gi*SEG + j];
                    // Per-bit cell choice: the approximate/exact boundary may sit mid-segment.
                    if (pax[gi] && (gi*SEG + j) < APPROX_BITS) begin
                        sum_d[gi*SEG + j] = y_bit;
                        c_apx             = x_bit;
                    end else begin
                        sum_d[gi*SEG + j] = x_bit ^ y_bit ^ c_apx;
                        c_apx             = (x_bit & y_bit) | (c_apx & (x_bit ^ y_bit));
                    end
                    esum_d[gi*SEG + j] = x_bit ^ y_bit ^ c_ext;
                    c_ext              = (x_bit & y_bit) | (c_ext & (x_bit ^ y_bit));
                end
                carry_d  = c_apx;
                ecarry_d = c_ext;
                // Only the last stage's flag is consumed; by then both chains are complete.
                exact_d  = ({c_apx, sum_d} == {c_ext, esum_d});
            end
        end

        // Stage register; reset discards whatever was in flight.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q  <= 1'b0;
                a_q      <= '0;
                b_q      <= '0;
                ax_q     <= 1'b0;
                sum_q    <= '0;
                carry_q  <= 1'b0;
                esum_q   <= '0;
                ecarry_q <= 1'b0;
                exact_q  <= 1'b0;
            end else begin
                valid_q  <= valid_d;
                a_q      <= a_d;
                b_q      <= b_d;
                ax_q     <= ax_d;
                sum_q    <= sum_d;
                carry_q  <= carry_d;
                esum_q   <= esum_d;
                ecarry_q <= ecarry_d;
                exact_q  <= exact_d;
            end
        end

        assign pv[gi+1]      = valid_q;
        assign pa[gi+1]      = a_q;
        assign pb[gi+1]      = b_q;
        assign pax[gi+1]     = ax_q;
        assign psum[gi+1]    = sum_q;
        assign pcarry[gi+1]  = carry_q;
        assign pesum[gi+1]   = esum_q;
        assign pecarry[gi+1] = ecarry_q;
        assign pexact[gi+1]  = exact_q;
    end

    assign out_valid = pv[STAGES];
    assign out_sum   = {pcarry[STAGES], psum[STAGES]};
    assign out_exact = pexact[STAGES];

    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             out_xfer;

    assign out_xfer = pv[STAGES] & out_ready;

    // Count delivered inexact sums, saturating; a clear always takes priority.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (out_xfer && !pexact[STAGES] && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_approx_rca_pipe.sv
// Testbench for approx_rca_pipe: directed scenarios plus randomized traffic
// with random backpressure, checked by a scoreboard against an arithmetic
// reference model of the approximate adder.
module tb_approx_rca_pipe;

    localparam int W    = 16;
    localparam int AB   = 8;
    localparam int ST   = 2;
    localparam int EW   = 4;
    localparam int EMAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          approx_en;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out_sum;
    logic          out_exact;
    logic [EW-1:0] err_cnt;
    logic          err_clr;

    always #5 clk = ~clk;

    approx_rca_pipe #(
        .WIDTH(W), .APPROX_BITS(AB), .STAGES(ST), .ERR_W(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_exact(out_exact),
        .err_cnt(err_cnt), .err_clr(err_clr)
    );

    typedef struct {
        logic [W:0] sum;
        logic       exact;
        int         c;
        logic       lat;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         exp_err = 0;
    logic [W:0] last_sum   = '0;
    logic       last_exact = 1'b0;
    logic       lat_chk = 1'b0;
    logic       rand_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: low AB bits copy Y, the carry into the exact part is X[AB-1].
    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic en);
        int unsigned lo, hi, cin;
        if (!en || AB == 0) return {1'b0, a} + {1'b0, b};
        lo  = 32'(b) & ((32'd1 << AB) - 32'd1);
        cin = (32'(a) >> (AB - 1)) & 32'd1;
        hi  = (32'(a) >> AB) + (32'(b) >> AB) + cin;
        return (W+1)'((hi << AB) | lo);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input side: every accepted operand pair pushes its expected result.
    always @(negedge clk) begin : in_mon
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.sum   = model_sum(in_a, in_b, approx_en);
            e.exact = (e.sum == ({1'b0, in_a} + {1'b0, in_b}));
            e.c     = cyc;
            e.lat   = lat_chk;
            sb.push_back(e);
        end
    end

    // Output side: pop and compare on each transfer, track the error counter.
    initial begin : out_mon
        exp_t       e;
        logic       held;
        logic [W:0] held_sum;
        logic       held_exact;
        held = 1'b0;
        held_sum = '0;
        held_exact = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_err = 0;
                held = 1'b0;
            end else begin
                chk("err_cnt", 32'(err_cnt), exp_err);
                if (held) begin
                    chk("hold_valid", 32'(out_valid), 1);
                    chk("hold_sum", 32'(out_sum), 32'(held_sum));
                    chk("hold_exact", 32'(out_exact), 32'(held_exact));
                end
                held       = out_valid && !out_ready;
                held_sum   = out_sum;
                held_exact = out_exact;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got sum 0x%0h, required no output", out_sum);
                    end else begin
                        e = sb.pop_front();
                        $display("[TB] out sum=0x%05h exact=%0d (expected 0x%05h exact=%0d)",
                                 out_sum, out_exact, e.sum, e.exact);
                        chk("sum", 32'(out_sum), 32'(e.sum));
                        chk("exact", 32'(out_exact), 32'(e.exact));
                        if (e.lat) chk("latency", cyc - e.c, ST);
                        last_sum   = out_sum;
                        last_exact = out_exact;
                        if (!e.exact && exp_err < EMAX) exp_err++;
                    end
                end
                if (err_clr) exp_err = 0;
            end
        end
    end

    // Random backpressure and counter clears during the randomized phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_on) begin
                out_ready = ($urandom_range(0, 3) != 0);
                err_clr   = ($urandom_range(0, 15) == 0);
            end
        end
    end

    task automatic wait_accept();
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        in_a      = a;
        in_b      = b;
        approx_en = en;
        in_valid  = 1'b1;
        wait_accept();
    endtask

    task automatic drain();
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        if (t == 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [W-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; approx_en = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_sum", 32'(out_sum), 0);
        chk("rst_out_exact", 32'(out_exact), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Carry generated inside the approximate segment
        lat_chk = 1'b1;
        send(16'h00FF, 16'h0001, 1'b1);
        lat_chk = 1'b0;
        drain();
        chk("t1_sum", 32'(last_sum), 32'h00101);
        chk("t1_exact", 32'(last_exact), 0);
        chk("t1_err", 32'(err_cnt), 1);

        // Same operands in exact mode
        send(16'h00FF, 16'h0001, 1'b0);
        drain();
        chk("t2_sum", 32'(last_sum), 32'h00100);
        chk("t2_exact", 32'(last_exact), 1);
        chk("t2_err", 32'(err_cnt), 1);

        // All-ones operands in both modes
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();
        chk("t3a_sum", 32'(last_sum), 32'h1FFFF);
        chk("t3a_exact", 32'(last_exact), 0);
        send(16'hFFFF, 16'hFFFF, 1'b0);
        drain();
        chk("t3b_sum", 32'(last_sum), 32'h1FFFE);
        chk("t3b_exact", 32'(last_exact), 1);

        // Output stalled for 5 cycles while 4 inputs are offered
        out_ready = 1'b0;
        send(16'h00F0, 16'h0010, 1'b1);
        send(16'h00F1, 16'h0010, 1'b1);
        in_a = 16'h00F2; in_b = 16'h0010; approx_en = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        fork
            begin
                wait_accept();
                send(16'h00F3, 16'h0010, 1'b1);
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("burst_valid", 32'(out_valid), 1);
                end
            end
        join
        drain();

        // Reset with two transactions in flight
        send(16'h1234, 16'h00FF, 1'b1);
        send(16'h00FF, 16'h00FF, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_out_valid", 32'(out_valid), 0);
        chk("rst2_err_cnt", 32'(err_cnt), 0);
        chk("rst2_in_ready", 32'(in_ready), 1);
        repeat (6) begin
            @(negedge clk);
            chk("rst2_no_stale", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;

        // Saturation, then a clear coinciding with a mismatching transfer
        repeat (20) send(16'h00FF, 16'h0001, 1'b1);
        drain();
        chk("sat_err_cnt", 32'(err_cnt), EMAX);
        send(16'h00FF, 16'h0001, 1'b1);
        repeat (ST - 1) begin
            @(posedge clk);
            #1;
        end
        chk("clr_setup_valid", 32'(out_valid), 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("clr_wins", 32'(err_cnt), 0);
        drain();

        // Randomized traffic with random backpressure and clears
        rand_on = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: ra = 16'hFFFF;
                1: ra = 16'h0080;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: rb = 16'hFFFF;
                1: rb = 16'h0000;
                default: rb = 16'($urandom);
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_on = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
